fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch stage and IF/ID pipeline register of the 5-stage MIPS pipeline; its if_id_instr[31:26] drives the decode-stage control unit's opcode input.
Owns the PC and a req/ack instruction-memory handshake with variable latency.
Handles decode-stage stalls with a one-entry hold buffer.
Handles branch redirects by squashing the fetched instruction and injecting the pipeline NOP, opcode 6'b100000.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INSTR, 32'h8000_0000, bubble word (opcode 100000, all other fields zero).
PC_STEP, 4, byte increment per sequential fetch.

Ports:
clk  in  1  pipeline clock, all state on rising edge.
rst  in  1  asynchronous, active-high reset.
stall  in  1  hazard unit: hold IF/ID and PC this cycle.
branch_taken  in  1  redirect request from branch resolution.
branch_target  in  32  redirect PC, valid when branch_taken=1.
imem_req  out  1  instruction read request.
imem_addr  out  32  read address, must stay stable while imem_req=1 and not acked.
imem_ack  in  1  read data valid this cycle; only meaningful while imem_req=1.
imem_rdata  in  32  instruction word, valid with imem_ack.
if_id_instr  out  32  instruction to decode.
if_id_npc  out  32  PC+4 of that instruction.
if_id_valid  out  1  1 = real instruction, 0 = bubble.

Behaviour:
- Reset (async, any state, mid-transaction included):
  - state=RST_S, pc=RESET_PC, addr_q=RESET_PC, imem_req=0.
  - if_id_instr=NOP_INSTR, if_id_npc=0, if_id_valid=0, hold buffer cleared.
  - Any ack arriving during reset is ignored.
- States:
  - RST_S: one cycle, imem_req=0, then REQ.
  - REQ: imem_req=1, imem_addr=addr_q, addr_q=pc on entry.
  - HOLD: imem_req=0; fetched word is buffered because of stall.
  - DROP: imem_req=1 with stale addr_q; response will be discarded.
- Priority each cycle: rst > branch_taken > stall > normal.
- REQ, no redirect:
  - ack & !stall: IF/ID <= {rdata, pc+4, valid=1}; pc <= pc+4; stay REQ; next request issues next cycle.
    - Best-case throughput is one instruction per 2 cycles (issue cycle, ack cycle); single-cycle ack memory is not back-to-back.
  - ack & stall: buffer <= {rdata, pc+4}; IF/ID held; go HOLD.
  - !ack & !stall: IF/ID <= {NOP_INSTR, 0, 0} (bubble).
  - !ack & stall: IF/ID held.
- HOLD:
  - stall: hold everything.
  - !stall: IF/ID <= buffer with valid=1; pc <= pc+4; go REQ.
- Redirect (branch_taken=1), from any non-reset state:
  - IF/ID <= {NOP_INSTR, 0, 0} regardless of stall.
  - pc <= branch_target.
  - Buffer discarded.
  - If in REQ/DROP with no ack this cycle: go DROP, since an outstanding request cannot be withdrawn.
  - Otherwise go REQ; a same-cycle ack is dropped.
- DROP: on ack, discard rdata and go REQ with addr_q <= pc. A second redirect while in DROP updates pc only.
- imem_addr changes only on entry to REQ; never while a request is unacked.
- Arithmetic: PC wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0). No alignment check; the low two bits pass through.
- Latency: ack in cycle N, instruction visible on IF/ID from N+1.

Decomposition:
- Shared pipeline package holds:
  - opcode constants: RTYPE, LW, SW, BEQ, NOP.
  - NOP_INSTR.
  - fetch state encoding: RST_S, REQ, HOLD, DROP.
- Natural sub-module: if_id_reg, the IF/ID register with load/flush/hold controls (instr, npc, valid).
- PC, FSM and hold buffer stay in fetch_stage.

Test Plan:
- Reset then 1-cycle-ack memory returning 0x0000_0020 and 0x8C01_0004 at 0x0, 0x4:
  - imem_addr 0x0, then 0x4.
  - IF/ID shows instr 0x0000_0020, npc 0x4, valid 1, followed by a bubble (valid 0), then 0x8C01_0004, npc 0x8.
- 3-cycle ack latency: IF/ID shows bubbles (instr 0x8000_0000, valid 0) while waiting; imem_addr stays stable until ack.
- Stall asserted in the ack cycle for 3 cycles: IF/ID unchanged for 3 cycles; buffered word appears the cycle stall drops; PC advances once.
- branch_taken with target 0x40 while a request to 0x8 is unacked:
  - IF/ID flushed to NOP_INSTR, valid 0.
  - The late ack for 0x8 is discarded.
  - Next imem_addr is 0x40.
- branch_taken same cycle as ack and stall: rdata dropped, IF/ID flushed, next fetch at target.
- rst asserted mid-DROP: outputs return to reset values asynchronously; first post-reset address is RESET_PC.
- PC wrap: fetch at 0xFFFF_FFFC yields next address 0x0 and npc 0x0.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions: opcode constants, the bubble instruction word
// and the fetch-stage state encoding.
package fetch_stage_pkg;

  // Primary opcodes (instr[31:26]) seen by the decode-stage control unit.
  localparam logic [5:0] RTYPE = 6'b000000;
  localparam logic [5:0] LW    = 6'b100011;
  localparam logic [5:0] SW    = 6'b101011;
  localparam logic [5:0] BEQ   = 6'b000100;
  localparam logic [5:0] NOP   = 6'b100000;

  // Pipeline bubble: NOP opcode with every other field zero.
  localparam logic [31:0] NOP_INSTR_WORD = {NOP, 26'd0};

  // Fetch controller states.
  typedef enum logic [1:0] {
    RST_S = 2'd0,  // first cycle after reset, no request yet
    REQ   = 2'd1,  // request outstanding at addr_q
    HOLD  = 2'd2,  // fetched word parked in the hold buffer during a stall
    DROP  = 2'd3   // request to a squashed address still outstanding
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory read channel: req/ack handshake with variable latency.
// The fetch stage is the master; the memory is the slave.
interface fetch_stage_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register. Flush (insert bubble) wins over load; with neither
// asserted the register holds its contents.
module fetch_stage_if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_WORD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_flush,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_npc,
  output logic [31:0] o_instr,
  output logic [31:0] o_npc,
  output logic        o_valid
);

  logic [31:0] r_instr;
  logic [31:0] r_npc;
  logic        r_valid;

  // Register update: bubble on reset/flush, capture on load, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr <= NOP_INSTR;
      r_npc   <= 32'd0;
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_instr <= NOP_INSTR;
      r_npc   <= 32'd0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_instr <= i_instr;
      r_npc   <= i_npc;
      r_valid <= 1'b1;
    end
  end

  assign o_instr = r_instr;
  assign o_npc   = r_npc;
  assign o_valid = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage of the 5-stage MIPS pipeline. Owns the PC, drives a
// req/ack instruction-memory read, parks a fetched word in a one-entry hold
// buffer while decode stalls, and squashes in-flight fetches on a redirect.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_WORD,
  parameter logic [31:0] PC_STEP   = 32'd4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 branch_taken,
  input  logic [31:0]          branch_target,
  fetch_stage_if.master        imem,
  output logic [31:0]          if_id_instr,
  output logic [31:0]          if_id_npc,
  output logic                 if_id_valid
);

  // Sequential PC increment; wraps modulo 2^32, low bits pass through.
  function automatic logic [31:0] f_pc_inc(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

  fetch_state_e r_state;
  fetch_state_e w_state_nxt;
  logic [31:0]  r_pc;
  logic [31:0]  w_pc_nxt;
  logic [31:0]  r_addr_q;
  logic [31:0]  w_addr_nxt;
  logic [31:0]  r_buf_instr;
  logic [31:0]  r_buf_npc;
  logic [31:0]  w_pc_inc;
  logic         w_buf_load;
  logic         w_buf_clear;
  logic         w_ifid_load;
  logic         w_ifid_flush;
  logic [31:0]  w_ifid_instr;
  logic [31:0]  w_ifid_npc;

  assign w_pc_inc = f_pc_inc(r_pc);

  // A request is on the bus whenever a fetch is outstanding, including a
  // squashed one that cannot be withdrawn.
  assign imem.imem_req  = (r_state == REQ) || (r_state == DROP);
  assign imem.imem_addr = r_addr_q;

  // State, PC, request address and hold buffer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= RST_S;
      r_pc        <= RESET_PC;
      r_addr_q    <= RESET_PC;
      r_buf_instr <= 32'd0;
      r_buf_npc   <= 32'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_addr_q <= w_addr_nxt;
      if (w_buf_clear) begin
        r_buf_instr <= 32'd0;
        r_buf_npc   <= 32'd0;
      end else if (w_buf_load) begin
        r_buf_instr <= imem.imem_rdata;
        r_buf_npc   <= w_pc_inc;
      end
    end
  end

  // Next-state and control decode; priority is redirect > stall > normal.
  // The request address only moves on entry to REQ, so it never changes
  // under an unacknowledged request.
  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_addr_nxt   = r_addr_q;
    w_buf_load   = 1'b0;
    w_buf_clear  = 1'b0;
    w_ifid_load  = 1'b0;
    w_ifid_flush = 1'b0;
    w_ifid_instr = imem.imem_rdata;
    w_ifid_npc   = w_pc_inc;

    unique case (r_state)
      RST_S: begin
        w_state_nxt = REQ;
        w_addr_nxt  = r_pc;
      end

      REQ: begin
        if (branch_taken) begin
          w_ifid_flush = 1'b1;
          w_buf_clear  = 1'b1;
          w_pc_nxt     = branch_target;
          if (imem.imem_ack) begin
            // Same-cycle response belongs to the squashed path: drop it.
            w_state_nxt = REQ;
            w_addr_nxt  = branch_target;
          end else begin
            w_state_nxt = DROP;
          end
        end else if (imem.imem_ack) begin
          if (stall) begin
            w_buf_load  = 1'b1;
            w_state_nxt = HOLD;
          end else begin
            w_ifid_load = 1'b1;
            w_pc_nxt    = w_pc_inc;
            w_addr_nxt  = w_pc_inc;
          end
        end else if (!stall) begin
          w_ifid_flush = 1'b1;
        end
      end

      HOLD: begin
        if (branch_taken) begin
          w_ifid_flush = 1'b1;
          w_buf_clear  = 1'b1;
          w_pc_nxt     = branch_target;
          w_addr_nxt   = branch_target;
          w_state_nxt  = REQ;
        end else if (!stall) begin
          w_ifid_load  = 1'b1;
          w_ifid_instr = r_buf_instr;
          w_ifid_npc   = r_buf_npc;
          w_pc_nxt     = w_pc_inc;
          w_addr_nxt   = w_pc_inc;
          w_state_nxt  = REQ;
        end
      end

      DROP: begin
        if (branch_taken) begin
          // A further redirect only retargets the PC; the stale request
          // still has to be drained.
          w_ifid_flush = 1'b1;
          w_buf_clear  = 1'b1;
          w_pc_nxt     = branch_target;
          if (imem.imem_ack) begin
            w_state_nxt = REQ;
            w_addr_nxt  = branch_target;
          end
        end else if (imem.imem_ack) begin
          w_state_nxt = REQ;
          w_addr_nxt  = r_pc;
        end
      end

      default: begin
        w_state_nxt = RST_S;
      end
    endcase
  end

  fetch_stage_if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_ifid_load),
    .i_flush (w_ifid_flush),
    .i_instr (w_ifid_instr),
    .i_npc   (w_ifid_npc),
    .o_instr (if_id_instr),
    .o_npc   (if_id_npc),
    .o_valid (if_id_valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a variable-latency memory responder, a
// fetch-behaviour model tracked as flags, a per-cycle compare, and literal
// checks at key points of each scenario.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_npc;
  logic        if_id_valid;

  fetch_stage_if imem_bus ();

  fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h8000_0000),
    .PC_STEP   (32'd4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem          (imem_bus),
    .if_id_instr   (if_id_instr),
    .if_id_npc     (if_id_npc),
    .if_id_valid   (if_id_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Memory responder state: ack arrives once the request has been seen for
  // more than lat cycles (lat=1 -> ack the cycle after issue).
  int   lat = 1;
  int   mem_cnt = 0;
  logic mem_ack_prev = 1'b0;

  // Behavioural model of the fetch stage.
  logic        m_started;
  logic        m_busy;      // a request is on the bus this cycle
  logic        m_discard;   // the outstanding response belongs to a squashed path
  logic        m_held;      // a fetched word waits for the stall to clear
  logic [31:0] m_pc;
  logic [31:0] m_fetch_addr;
  logic [31:0] m_hold_instr;
  logic [31:0] m_hold_npc;
  logic [31:0] m_if_instr;
  logic [31:0] m_if_npc;
  logic        m_if_valid;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0000) return 32'h0000_0020;
    if (a == 32'h0000_0004) return 32'h8C01_0004;
    return {8'h24, a[23:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_started    = 1'b0;
    m_busy       = 1'b0;
    m_discard    = 1'b0;
    m_held       = 1'b0;
    m_pc         = 32'h0000_0000;
    m_fetch_addr = 32'h0000_0000;
    m_hold_instr = 32'h0;
    m_hold_npc   = 32'h0;
    m_if_instr   = 32'h8000_0000;
    m_if_npc     = 32'h0;
    m_if_valid   = 1'b0;
  endtask

  task automatic model_bubble();
    m_if_instr = 32'h8000_0000;
    m_if_npc   = 32'h0;
    m_if_valid = 1'b0;
  endtask

  // One cycle of fetch behaviour given this cycle's inputs.
  task automatic model_step(input logic s, input logic b, input logic [31:0] t,
                            input logic ack, input logic [31:0] rdata);
    logic acked;
    acked = m_busy && ack;
    if (!m_started) begin
      m_started    = 1'b1;
      m_busy       = 1'b1;
      m_fetch_addr = m_pc;
    end else if (b) begin
      model_bubble();
      m_pc   = t;
      m_held = 1'b0;
      if (m_busy && !acked) begin
        m_discard = 1'b1;
      end else begin
        m_discard    = 1'b0;
        m_busy       = 1'b1;
        m_fetch_addr = t;
      end
    end else if (m_discard) begin
      if (acked) begin
        m_discard    = 1'b0;
        m_fetch_addr = m_pc;
      end
    end else if (m_held) begin
      if (!s) begin
        m_if_instr   = m_hold_instr;
        m_if_npc     = m_hold_npc;
        m_if_valid   = 1'b1;
        m_pc         = m_pc + 32'd4;
        m_held       = 1'b0;
        m_busy       = 1'b1;
        m_fetch_addr = m_pc;
      end
    end else if (acked) begin
      if (s) begin
        m_held       = 1'b1;
        m_hold_instr = rdata;
        m_hold_npc   = m_pc + 32'd4;
        m_busy       = 1'b0;
      end else begin
        m_if_instr   = rdata;
        m_if_npc     = m_pc + 32'd4;
        m_if_valid   = 1'b1;
        m_pc         = m_pc + 32'd4;
        m_fetch_addr = m_pc;
      end
    end else if (!s) begin
      model_bubble();
    end
  endtask

  task automatic compare_all();
    chk("imem_req", {31'd0, imem_bus.imem_req}, {31'd0, m_busy});
    if (m_busy) chk("imem_addr", imem_bus.imem_addr, m_fetch_addr);
    chk("if_id_instr", if_id_instr, m_if_instr);
    chk("if_id_npc", if_id_npc, m_if_npc);
    chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, m_if_valid});
  endtask

  // Drive one cycle of inputs, respond as memory, advance the model, then
  // compare just after the edge.
  task automatic step(input logic s, input logic b, input logic [31:0] t);
    logic ack;
    stall         = s;
    branch_taken  = b;
    branch_target = t;
    if (mem_ack_prev) mem_cnt = 0;
    if (imem_bus.imem_req) begin
      mem_cnt++;
      ack = (mem_cnt > lat);
    end else begin
      mem_cnt = 0;
      ack     = 1'b0;
    end
    imem_bus.imem_ack   = ack;
    imem_bus.imem_rdata = ack ? mem_word(imem_bus.imem_addr) : 32'hDEAD_BEEF;
    mem_ack_prev        = ack;
    model_step(s, b, t, ack, imem_bus.imem_rdata);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  // Reset asserted mid-cycle; a spurious ack is driven while reset is held.
  task automatic async_reset_mid();
    #2;
    rst                 = 1'b1;
    stall               = 1'b0;
    branch_taken        = 1'b0;
    imem_bus.imem_ack   = 1'b1;
    imem_bus.imem_rdata = 32'h1234_5678;
    #1;
    model_reset();
    compare_all();
    chk("async_rst_req", {31'd0, imem_bus.imem_req}, 32'd0);
    chk("async_rst_instr", if_id_instr, 32'h8000_0000);
    @(posedge clk);
    @(posedge clk);
    #1;
    compare_all();
    imem_bus.imem_ack   = 1'b0;
    mem_cnt             = 0;
    mem_ack_prev        = 1'b0;
    rst                 = 1'b0;
  endtask

  initial begin
    rst                 = 1'b1;
    stall               = 1'b0;
    branch_taken        = 1'b0;
    branch_target       = 32'h0;
    imem_bus.imem_ack   = 1'b0;
    imem_bus.imem_rdata = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    chk("rst_instr", if_id_instr, 32'h8000_0000);
    chk("rst_npc", if_id_npc, 32'h0);
    chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
    chk("rst_req", {31'd0, imem_bus.imem_req}, 32'd0);
    rst = 1'b0;

    // Single-cycle-ack memory: one instruction every two cycles.
    lat = 1;
    step(1'b0, 1'b0, 32'h0);
    chk("first_addr", imem_bus.imem_addr, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    chk("i0_instr", if_id_instr, 32'h0000_0020);
    chk("i0_npc", if_id_npc, 32'h4);
    chk("i0_valid", {31'd0, if_id_valid}, 32'd1);
    chk("second_addr", imem_bus.imem_addr, 32'h4);
    step(1'b0, 1'b0, 32'h0);
    chk("gap_valid", {31'd0, if_id_valid}, 32'd0);
    step(1'b0, 1'b0, 32'h0);
    chk("i1_instr", if_id_instr, 32'h8C01_0004);
    chk("i1_npc", if_id_npc, 32'h8);

    // Three-cycle latency: bubbles while waiting, address stable.
    lat = 3;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 32'h0);
      chk("wait_instr", if_id_instr, 32'h8000_0000);
      chk("wait_addr", imem_bus.imem_addr, 32'h8);
    end
    step(1'b0, 1'b0, 32'h0);
    chk("lat3_instr", if_id_instr, 32'h2400_0008);
    chk("lat3_npc", if_id_npc, 32'hC);

    // Stall held for three cycles starting in the ack cycle.
    lat = 1;
    step(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 32'h0);
      chk("stall_valid", {31'd0, if_id_valid}, 32'd0);
      chk("stall_req", {31'd0, imem_bus.imem_req}, 32'd0);
    end
    step(1'b0, 1'b0, 32'h0);
    chk("unhold_instr", if_id_instr, 32'h2400_000C);
    chk("unhold_npc", if_id_npc, 32'h10);
    chk("unhold_addr", imem_bus.imem_addr, 32'h10);
    // Stall with no ack keeps a real instruction in IF/ID.
    step(1'b1, 1'b0, 32'h0);
    chk("held_instr", if_id_instr, 32'h2400_000C);
    chk("held_valid", {31'd0, if_id_valid}, 32'd1);
    step(1'b0, 1'b0, 32'h0);
    chk("after_held_instr", if_id_instr, 32'h2400_0010);

    // Redirect while a request is unacknowledged: late ack is discarded.
    lat = 3;
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h40);
    chk("drop_instr", if_id_instr, 32'h8000_0000);
    chk("drop_stale_addr", imem_bus.imem_addr, 32'h14);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    chk("drop_valid", {31'd0, if_id_valid}, 32'd0);
    chk("redirect_addr", imem_bus.imem_addr, 32'h40);

    // Redirect in the same cycle as ack and stall.
    lat = 1;
    step(1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h80);
    chk("bas_addr", imem_bus.imem_addr, 32'h80);
    chk("bas_valid", {31'd0, if_id_valid}, 32'd0);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    chk("tgt_instr", if_id_instr, 32'h2400_0080);
    chk("tgt_npc", if_id_npc, 32'h84);

    // Redirect while a word is parked in the hold buffer.
    step(1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'hC0);
    chk("hold_br_addr", imem_bus.imem_addr, 32'hC0);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    chk("hold_br_instr", if_id_instr, 32'h2400_00C0);

    // Asynchronous reset in DROP.
    lat = 3;
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h100);
    async_reset_mid();
    lat = 1;
    step(1'b0, 1'b0, 32'h0);
    chk("post_rst_addr", imem_bus.imem_addr, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    chk("post_rst_instr", if_id_instr, 32'h0000_0020);

    // Two redirects inside DROP, then a fetch across the top of memory.
    lat = 3;
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h200);
    step(1'b0, 1'b1, 32'hFFFF_FFFC);
    chk("drop2_addr", imem_bus.imem_addr, 32'h4);
    step(1'b0, 1'b0, 32'h0);
    chk("wrap_fetch_addr", imem_bus.imem_addr, 32'hFFFF_FFFC);
    lat = 1;
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    chk("wrap_instr", if_id_instr, 32'h24FF_FFFC);
    chk("wrap_npc", if_id_npc, 32'h0);
    chk("wrap_next_addr", imem_bus.imem_addr, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    chk("wrap_after_instr", if_id_instr, 32'h0000_0020);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
